// File: rtl/fingerclip_cal_ctrl_pkg.sv
// Shared types and widths for the finger-clip auto-calibration controller.
package fingerclip_cal_ctrl_pkg;

    localparam int DC_W   = 7;
    localparam int GAIN_W = 4;
    localparam int VPPG_W = 8;
    localparam logic [GAIN_W-1:0] GAIN_MAX = 4'd15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DC_SETTLE,
        ST_DC_MEAS,
        ST_DC_EVAL,
        ST_G_SETTLE,
        ST_G_MEAS,
        ST_G_EVAL,
        ST_TRACK_MEAS,
        ST_TRACK_EVAL
    } state_t;

endpackage

// File: rtl/fingerclip_cal_ctrl_if.sv
// Sample stream in, analog configuration and status out, between ADC side and controller.
interface fingerclip_cal_ctrl_if;
    import fingerclip_cal_ctrl_pkg::*;

    logic              start;
    logic [VPPG_W-1:0] vppg;
    logic              vppg_valid;
    logic [DC_W-1:0]   dc_comp;
    logic [GAIN_W-1:0] pga_gain;
    logic              busy;
    logic              done;
    logic              error;

    modport master (output start, vppg, vppg_valid,
                    input  dc_comp, pga_gain, busy, done, error);
    modport slave  (input  start, vppg, vppg_valid,
                    output dc_comp, pga_gain, busy, done, error);
endinterface

// File: rtl/fingerclip_cal_ctrl_stats.sv
// Per-measurement sample counter: discards settle samples, then tracks min/max over one window.
module ppg_window_stats
    import fingerclip_cal_ctrl_pkg::*;
#(
    parameter int SETTLE_SAMPLES = 16,
    parameter int WINDOW_SAMPLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_clear,
    input  logic              i_valid,
    input  logic [VPPG_W-1:0] i_sample,
    output logic              o_settled,
    output logic              o_win_done,
    output logic [VPPG_W-1:0] o_min,
    output logic [VPPG_W-1:0] o_max
);
    localparam int TOTAL = SETTLE_SAMPLES + WINDOW_SAMPLES;
    localparam int CNT_W = $clog2(TOTAL + 1);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_win_done;
    logic [VPPG_W-1:0] r_min;
    logic [VPPG_W-1:0] r_max;
    logic              w_in_window;

    assign w_in_window = (r_cnt >= CNT_W'(SETTLE_SAMPLES)) && (r_cnt < CNT_W'(TOTAL));

    // Once the window is full the counter parks, so late samples cannot disturb min/max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_win_done <= 1'b0;
            r_min      <= '1;
            r_max      <= '0;
        end else begin
            r_win_done <= 1'b0;
            if (i_clear) begin
                r_cnt <= '0;
                r_min <= '1;
                r_max <= '0;
            end else if (i_valid && (r_cnt < CNT_W'(TOTAL))) begin
                r_cnt <= r_cnt + CNT_W'(1);
                if (w_in_window) begin
                    if (i_sample < r_min) r_min <= i_sample;
                    if (i_sample > r_max) r_max <= i_sample;
                end
                if (r_cnt == CNT_W'(TOTAL - 1)) r_win_done <= 1'b1;
            end
        end
    end

    assign o_settled  = (r_cnt >= CNT_W'(SETTLE_SAMPLES));
    assign o_win_done = r_win_done;
    assign o_min      = r_min;
    assign o_max      = r_max;
endmodule

// File: rtl/fingerclip_cal_ctrl.sv
// Calibration FSM: SAR search on DC compensation, then gain ramp to the largest non-clipping step, then tracking.
module fingerclip_cal_ctrl
    import fingerclip_cal_ctrl_pkg::*;
#(
    parameter int SETTLE_SAMPLES = 16,
    parameter int WINDOW_SAMPLES = 64,
    parameter int TARGET_MID     = 128,
    parameter int LOW_TH         = 32,
    parameter int HIGH_TH        = 223,
    parameter int TIMEOUT_CYC    = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fingerclip_cal_ctrl_if.slave bus
);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    state_t            r_state, w_state_next;
    logic [DC_W-1:0]   r_dc, w_dc_next;
    logic [GAIN_W-1:0] r_gain, w_gain_next;
    logic [2:0]        r_ptr, w_ptr_next;
    logic              r_error, w_error_next;
    logic [TO_W-1:0]   r_to_cnt;

    logic              w_busy, w_track, w_eval, w_clear, w_start_acc, w_timeout, w_clip;
    logic              w_settled, w_win_done;
    logic [VPPG_W-1:0] w_min, w_max, w_mid;
    logic [VPPG_W:0]   w_sum;

    assign w_busy  = (r_state inside {ST_DC_SETTLE, ST_DC_MEAS, ST_DC_EVAL,
                                      ST_G_SETTLE, ST_G_MEAS, ST_G_EVAL});
    assign w_track = (r_state inside {ST_TRACK_MEAS, ST_TRACK_EVAL});
    assign w_eval  = (r_state inside {ST_DC_EVAL, ST_G_EVAL, ST_TRACK_EVAL});

    assign w_start_acc = bus.start && !w_busy;
    // Clearing in every EVAL cycle drops any sample arriving there and restarts the settle count.
    assign w_clear     = w_eval || w_start_acc || (r_state == ST_IDLE);
    assign w_timeout   = w_busy && !bus.vppg_valid && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    assign w_sum  = {1'b0, w_min} + {1'b0, w_max};
    assign w_mid  = VPPG_W'(w_sum >> 1);
    assign w_clip = (w_max >= VPPG_W'(HIGH_TH)) || (w_min <= VPPG_W'(LOW_TH));

    ppg_window_stats #(
        .SETTLE_SAMPLES(SETTLE_SAMPLES),
        .WINDOW_SAMPLES(WINDOW_SAMPLES)
    ) u_stats (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .i_valid   (bus.vppg_valid),
        .i_sample  (bus.vppg),
        .o_settled (w_settled),
        .o_win_done(w_win_done),
        .o_min     (w_min),
        .o_max     (w_max)
    );

    always_comb begin
        w_state_next = r_state;
        w_dc_next    = r_dc;
        w_gain_next  = r_gain;
        w_ptr_next   = r_ptr;
        w_error_next = r_error;
        case (r_state)
            ST_DC_SETTLE:  if (w_settled)  w_state_next = ST_DC_MEAS;
            ST_DC_MEAS:    if (w_win_done) w_state_next = ST_DC_EVAL;
            ST_DC_EVAL: begin
                // Larger dc_comp pulls Vppg down, so a high midpoint keeps the trial bit.
                if (!(w_mid > VPPG_W'(TARGET_MID))) w_dc_next[r_ptr] = 1'b0;
                if (r_ptr != 3'd0) begin
                    w_dc_next[r_ptr - 3'd1] = 1'b1;
                    w_ptr_next   = r_ptr - 3'd1;
                    w_state_next = ST_DC_SETTLE;
                end else begin
                    w_gain_next  = GAIN_W'(1);
                    w_state_next = ST_G_SETTLE;
                end
            end
            ST_G_SETTLE:   if (w_settled)  w_state_next = ST_G_MEAS;
            ST_G_MEAS:     if (w_win_done) w_state_next = ST_G_EVAL;
            ST_G_EVAL: begin
                if (w_clip) begin
                    w_gain_next = r_gain - GAIN_W'(1);
                    if (r_gain == GAIN_W'(1)) begin
                        w_error_next = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_state_next = ST_TRACK_MEAS;
                    end
                end else if (r_gain == GAIN_MAX) begin
                    w_state_next = ST_TRACK_MEAS;
                end else begin
                    w_gain_next  = r_gain + GAIN_W'(1);
                    w_state_next = ST_G_SETTLE;
                end
            end
            ST_TRACK_MEAS: if (w_win_done) w_state_next = ST_TRACK_EVAL;
            ST_TRACK_EVAL: begin
                if (w_clip && (r_gain != '0)) w_gain_next = r_gain - GAIN_W'(1);
                w_state_next = ST_TRACK_MEAS;
            end
            default:       w_state_next = ST_IDLE;
        endcase
        if (w_start_acc) begin
            w_dc_next    = DC_W'(7'h40);
            w_gain_next  = '0;
            w_ptr_next   = 3'd6;
            w_error_next = 1'b0;
            w_state_next = ST_DC_SETTLE;
        end
        if (w_timeout) begin
            w_error_next = 1'b1;
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_dc     <= '0;
            r_gain   <= '0;
            r_ptr    <= '0;
            r_error  <= 1'b0;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_dc     <= w_dc_next;
            r_gain   <= w_gain_next;
            r_ptr    <= w_ptr_next;
            r_error  <= w_error_next;
            r_to_cnt <= (!w_busy || bus.vppg_valid || w_timeout) ? '0 : r_to_cnt + TO_W'(1);
        end
    end

    assign bus.dc_comp  = r_dc;
    assign bus.pga_gain = r_gain;
    assign bus.busy     = w_busy;
    assign bus.done     = w_track;
    assign bus.error    = r_error;
endmodule

// File: tb/tb_fingerclip_cal_ctrl.sv
// Directed bench: a simple optical model reacts to dc_comp/pga_gain; expected values are hand-derived.
module tb_fingerclip_cal_ctrl;
    logic clk;
    logic rst_n;

    fingerclip_cal_ctrl_if bus();

    fingerclip_cal_ctrl #(
        .SETTLE_SAMPLES(2),
        .WINDOW_SAMPLES(4),
        .TARGET_MID    (128),
        .LOW_TH        (32),
        .HIGH_TH       (223),
        .TIMEOUT_CYC   (4096)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int valid_mode = 1;
    int offset = 0;
    bit force_rail = 1'b0;
    bit tog = 1'b0;
    int cyc = 0;
    int dc_q[$];
    int dc_t[$];
    int gain_q[$];

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end else begin
            $display("chk  %s: got %0d", tag, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Sample model: alternating hi/lo around 255-2*dc, spread 16 per gain step.
    initial begin
        int b, v;
        bus.start      = 1'b0;
        bus.vppg       = '0;
        bus.vppg_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (valid_mode == 0) begin
                bus.vppg_valid = 1'b0;
            end else begin
                tog = !tog;
                b = 255 - 2 * int'(bus.dc_comp) + offset;
                v = tog ? b + 16 * int'(bus.pga_gain) : b - 16 * int'(bus.pga_gain);
                if (v > 255) v = 255;
                if (v < 0) v = 0;
                if (force_rail) v = tog ? 255 : 0;
                bus.vppg       = 8'(v);
                bus.vppg_valid = 1'b1;
            end
        end
    end

    // Record every change of dc_comp / pga_gain with its cycle stamp.
    initial begin
        int prev_dc, prev_g;
        prev_dc = 0;
        prev_g  = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (int'(bus.dc_comp) != prev_dc) begin
                prev_dc = int'(bus.dc_comp);
                dc_q.push_back(prev_dc);
                dc_t.push_back(cyc);
            end
            if (int'(bus.pga_gain) != prev_g) begin
                prev_g = int'(bus.pga_gain);
                gain_q.push_back(prev_g);
            end
        end
    end

    initial begin
        int exp_dc[7];
        int exp_g[7];
        int n;
        exp_dc = '{64, 32, 48, 56, 60, 62, 63};
        exp_g  = '{1, 2, 3, 4, 5, 6, 5};

        // Reset state
        rst_n = 1'b0;
        tick(3);
        chk("rst_dc", int'(bus.dc_comp), 0);
        chk("rst_gain", int'(bus.pga_gain), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_error", int'(bus.error), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full calibration: SAR path, gain ramp, back-off at gain 6
        @(negedge clk);
        dc_q.delete(); dc_t.delete(); gain_q.delete();
        pulse_start();
        n = 0;
        while (!bus.done && n < 2000) begin tick(1); n++; end
        chk("t1_done", int'(bus.done), 1);
        chk("t1_busy", int'(bus.busy), 0);
        chk("t1_error", int'(bus.error), 0);
        chk("t1_dc_changes", dc_q.size(), 7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("t1_dc_step%0d", i), (i < dc_q.size()) ? dc_q[i] : -1, exp_dc[i]);
        chk("t1_gain_changes", gain_q.size(), 7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("t1_gain_step%0d", i), (i < gain_q.size()) ? gain_q[i] : -1, exp_g[i]);
        chk("t1_eval_period", (dc_t.size() > 1) ? dc_t[1] - dc_t[0] : -1, 8);

        // Tracking: signal shifts up, one back-off only, never climbs again
        offset = 20;
        n = 0;
        while (bus.pga_gain == 4'd5 && n < 200) begin tick(1); n++; end
        chk("t3_gain_drop", int'(bus.pga_gain), 4);
        chk("t3_dc_frozen", int'(bus.dc_comp), 63);
        chk("t3_done", int'(bus.done), 1);
        tick(40);
        chk("t3_gain_hold", int'(bus.pga_gain), 4);
        offset = 0;
        tick(40);
        chk("t3_no_incr", int'(bus.pga_gain), 4);

        // Restart from TRACK; a start while busy is ignored
        @(negedge clk);
        dc_q.delete(); dc_t.delete(); gain_q.delete();
        pulse_start();
        chk("t6_dc_init", int'(bus.dc_comp), 64);
        chk("t6_gain_init", int'(bus.pga_gain), 0);
        chk("t6_busy", int'(bus.busy), 1);
        chk("t6_done_clr", int'(bus.done), 0);
        n = 0;
        while (bus.dc_comp != 7'd32 && n < 100) begin tick(1); n++; end
        pulse_start();
        chk("t6_start_ignored", int'(bus.dc_comp), 32);
        n = 0;
        while (!bus.done && n < 2000) begin tick(1); n++; end
        chk("t6_window_len", (dc_t.size() > 2) ? dc_t[2] - dc_t[1] : -1, 8);
        chk("t6_final_gain", int'(bus.pga_gain), 5);
        chk("t6_final_dc", int'(bus.dc_comp), 63);

        // Timeout in the gain phase
        pulse_start();
        n = 0;
        while (bus.pga_gain != 4'd1 && n < 200) begin tick(1); n++; end
        tick(3);
        valid_mode = 0;
        tick(4000);
        chk("t5_no_early_err", int'(bus.error), 0);
        chk("t5_still_busy", int'(bus.busy), 1);
        tick(200);
        chk("t5_error", int'(bus.error), 1);
        chk("t5_idle", int'(bus.busy), 0);
        chk("t5_dc_hold", int'(bus.dc_comp), 63);
        chk("t5_gain_hold", int'(bus.pga_gain), 1);
        valid_mode = 1;
        pulse_start();
        chk("t5_err_clr", int'(bus.error), 0);
        chk("t5_restart_dc", int'(bus.dc_comp), 64);

        // Asynchronous reset in the middle of the DC search
        n = 0;
        while (bus.dc_comp != 7'd48 && n < 100) begin tick(1); n++; end
        chk("t2_reached_48", int'(bus.dc_comp), 48);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t2_dc", int'(bus.dc_comp), 0);
        chk("t2_gain", int'(bus.pga_gain), 0);
        chk("t2_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);
        chk("t2_stays_idle", int'(bus.busy), 0);

        // Rail-to-rail signal: DC walks to 0, gain 1 clips -> error
        force_rail = 1'b1;
        pulse_start();
        n = 0;
        while (!bus.error && n < 2000) begin tick(1); n++; end
        chk("t4_error", int'(bus.error), 1);
        chk("t4_gain", int'(bus.pga_gain), 0);
        chk("t4_done", int'(bus.done), 0);
        chk("t4_busy", int'(bus.busy), 0);
        chk("t4_dc", int'(bus.dc_comp), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
